mul_arb: RTL and testbench
==========================

# mul_arb

Round-robin arbiter and sequencer that shares one multi-cycle `mul_` unit among `N_REQ` requesters. It accepts operand pairs over per-requester valid/ready handshakes and issues a single-cycle `start` to the multiplier. It holds the operands stable until `done`, then returns the 32-bit product to the owning requester over a per-requester response handshake. It sits between the CNN PE/accumulator clients and the shared `mul_` instance.

## Interface
- `N_REQ`, 4, number of requesters (2..8)
- `DATA_W`, 16, operand width; product width `RES_W = 2*DATA_W`
- `clk`  in  1  rising-edge clock
- `reset`  in  1  synchronous, active-high reset
- `req_valid`  in  N_REQ  per-requester operand valid
- `req_ready`  out  N_REQ  one-hot accept; at most one bit high per cycle
- `req_a`, `req_b`  in  N_REQ*DATA_W  flattened operands; requester i occupies `[i*DATA_W +: DATA_W]`
- `rsp_valid`  out  N_REQ  one-hot result valid
- `rsp_ready`  in  N_REQ  per-requester result accept
- `rsp_data`  out  RES_W  product, shared bus
- `rsp_id`  out  clog2(N_REQ)  index of the owning requester
- `mul_start`  out  1  one-cycle start pulse to `mul_`
- `mul_in1`, `mul_in2`  out  DATA_W  operands to `mul_`; stable from ISSUE until `mul_done`
- `mul_out`  in  RES_W  product from `mul_`; valid when `mul_done` is high
- `mul_done`  in  1  one-cycle completion pulse from `mul_`

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP. One transaction is in flight at a time.
- **IDLE**
  - Picker searches `req_valid` starting at `ptr`, wrapping modulo N_REQ.
  - The first set bit is granted: `req_ready[g]` is driven combinationally high in that same cycle.
  - On `req_valid[g] & req_ready[g]`: latch `a`, `b` and `id = g`; set `ptr <= (g+1) mod N_REQ`; go to ISSUE.
  - With no valid request, stay in IDLE.
- **ISSUE**
  - `mul_start = 1` for exactly this cycle.
  - `mul_in1 = a` and `mul_in2 = b`, registered.
  - Go to WAIT.
- **WAIT**
  - Hold `mul_in1` and `mul_in2`.
  - On `mul_done`: capture `mul_out` into the result register and go to RESP.
- **RESP**
  - `rsp_valid[id] = 1`, `rsp_data = result`, `rsp_id = id`.
  - Hold all three until `rsp_ready[id]`, then return to IDLE.
  - `rsp_ready` bits other than `id` are ignored.
- `req_ready` is all-zero in every state except IDLE, so back-to-back accepts are impossible.
- `mul_done` seen in IDLE, ISSUE or RESP is ignored; no state or output changes.
- Arithmetic: unsigned; the product is passed through unmodified, with no truncation.

## Timing
- Reset values: FSM = IDLE, `ptr = 0`, `req_ready = 0`, `rsp_valid = 0`, `rsp_data = 0`, `rsp_id = 0`, `mul_start = 0`, `mul_in1 = 0`, `mul_in2 = 0`.
- Reset mid-transaction:
  - Any pending operands or result are discarded.
  - No response is issued.
  - `mul_` shares `reset`, so it is reset in the same cycle.
- Latency, with the accept at cycle T:
  - `mul_start` at T+1.
  - `mul_done` at T+1+L, where L is the `mul_` latency.
  - `rsp_valid` from T+2+L.
- If `rsp_ready` is already high, the next accept can occur at T+3+L.
- Fairness: with all requesters continuously valid, grants rotate 0,1,2,3,0,…

## Configuration
- `MUL_ARB_ZERO_BYPASS_EN`, when defined:
  - In IDLE, an accepted request with `a == 0` or `b == 0` skips ISSUE and WAIT.
  - The result register is set to 0 and the FSM goes straight to RESP, so `rsp_valid` appears at T+1.
  - No `mul_start` is issued.
  - The `ptr` update is unchanged.
- When the macro is undefined, zero operands take the normal path.

## Structure
- `mul_arb_pkg`:
  - state enum `mul_arb_state_t`
  - `DATA_W` and `RES_W` defaults
  - `id_w(n)` helper (clog2)
- Sub-module `rr_pick`: combinational N-bit round-robin picker.
  - Inputs: `req`, `ptr`.
  - Outputs: one-hot `gnt`, encoded `idx`, `any`.
- Reused for the arbitration in IDLE.

## Test plan
- **Single request.** After reset, requester 0 presents a=8648, b=2301.
  - Required: one `mul_start` pulse, `mul_in1`/`mul_in2` held until `mul_done`.
  - Required: `rsp_valid[0]` with `rsp_data` = 19899048 and `rsp_id` = 0.
- **Round-robin.** All 4 requesters valid, with operand pairs (3,5), (7,11), (13,17), (65535,65535).
  - Required: grants in order 0,1,2,3.
  - Required: results 15, 77, 221, 4294836225 on the matching `rsp_id`.
- **Response backpressure.** Hold `rsp_ready[1]` low for 10 cycles.
  - Required: `rsp_valid`, `rsp_data` and `rsp_id` are stable for those cycles.
  - Required: no `req_ready` is asserted until after `rsp_ready[1]` is high.
- **Spurious done.** Pulse `mul_done` while in IDLE.
  - Required: no `rsp_valid`; `ptr` unchanged.
- **Reset in WAIT.** Assert `reset` for 1 cycle.
  - Required: all outputs at their reset values the next cycle.
  - Required: no response is issued for the aborted request.
- **Zero operand.** Requester 2 presents a=0, b=1234.
  - With `MUL_ARB_ZERO_BYPASS_EN` defined: `rsp_data` = 0 at T+1 and no `mul_start`.
  - Without the macro: `rsp_data` = 0 via the full multiplier path.

Source files
------------

// File: rtl/mul_arb_pkg.sv
// Shared types and defaults for the mul_arb multiplier arbiter/sequencer.
package mul_arb_pkg;

  localparam int DATA_W_DEFAULT = 16;
  localparam int RES_W_DEFAULT  = 2 * DATA_W_DEFAULT;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } mul_arb_state_t;

  // Width of a requester index; never narrower than one bit.
  function automatic int id_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mul_arb_if.sv
// Requester-side bus of mul_arb: operand request and product response handshakes.
interface mul_arb_if
  import mul_arb_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int DATA_W = DATA_W_DEFAULT
);
  localparam int RES_W = 2 * DATA_W;
  localparam int ID_W  = id_w(N_REQ);

  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ-1:0]        req_ready;
  logic [N_REQ*DATA_W-1:0] req_a;
  logic [N_REQ*DATA_W-1:0] req_b;
  logic [N_REQ-1:0]        rsp_valid;
  logic [N_REQ-1:0]        rsp_ready;
  logic [RES_W-1:0]        rsp_data;
  logic [ID_W-1:0]         rsp_id;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_id
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_id
  );

endinterface

// File: rtl/mul_arb_rr_pick.sv
// Combinational round-robin picker: first set bit of req at or after ptr, wrapping.
module rr_pick
  import mul_arb_pkg::*;
#(
  parameter  int N  = 4,
  localparam int IW = id_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  always_comb begin
    int j;
    // NOTE: every output gets a default before the loop, so no path infers a latch.
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = 0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr) + k) % N;
      if (!any && req[j]) begin
        gnt[j] = 1'b1;
        idx    = IW'(j);
        any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mul_arb.sv
// Round-robin arbiter sharing one multi-cycle multiplier among N_REQ requesters.
// Optional: define MUL_ARB_ZERO_BYPASS_EN to answer zero-operand requests without the multiplier.
module mul_arb
  import mul_arb_pkg::*;
#(
  parameter  int N_REQ  = 4,
  parameter  int DATA_W = DATA_W_DEFAULT,
  localparam int RES_W  = 2 * DATA_W,
  localparam int ID_W   = id_w(N_REQ)
) (
  input  logic              clk,
  input  logic              reset,
  mul_arb_if.slave          bus,
  output logic              mul_start,
  output logic [DATA_W-1:0] mul_in1,
  output logic [DATA_W-1:0] mul_in2,
  input  logic [RES_W-1:0]  mul_out,
  input  logic              mul_done
);

  mul_arb_state_t    state_q, state_d;
  logic [ID_W-1:0]   ptr_q, ptr_next;
  logic [ID_W-1:0]   id_q;
  logic [RES_W-1:0]  result_q;
  logic [N_REQ-1:0]  gnt;
  logic [ID_W-1:0]   idx;
  logic              any;
  logic [DATA_W-1:0] a_sel, b_sel;
  logic              accept;
  logic              bypass;

  rr_pick #(.N(N_REQ)) u_pick (
    .req (bus.req_valid),
    .ptr (ptr_q),
    .gnt (gnt),
    .idx (idx),
    .any (any)
  );

  assign a_sel    = bus.req_a[idx*DATA_W +: DATA_W];
  assign b_sel    = bus.req_b[idx*DATA_W +: DATA_W];
  assign accept   = (state_q == ST_IDLE) && any;
  assign ptr_next = (idx == ID_W'(N_REQ - 1)) ? '0 : idx + 1'b1;

`ifdef MUL_ARB_ZERO_BYPASS_EN
  assign bypass = (a_sel == '0) || (b_sel == '0);
`else
  assign bypass = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept) state_d = bypass ? ST_RESP : ST_ISSUE;
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT:  if (mul_done) state_d = ST_RESP;
      ST_RESP:  if (bus.rsp_ready[id_q]) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready = '0;
    bus.rsp_valid = '0;
    mul_start     = 1'b0;
    case (state_q)
      ST_IDLE:  bus.req_ready = gnt;
      ST_ISSUE: mul_start = 1'b1;
      ST_RESP:  bus.rsp_valid[id_q] = 1'b1;
      default:  ;
    endcase
  end

  assign bus.rsp_data = result_q;
  assign bus.rsp_id   = id_q;

  // Operands load straight into the multiplier input registers at accept and stay put until
  // the next accept, which covers the whole ISSUE..WAIT window.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q    <= '0;
      id_q     <= '0;
      result_q <= '0;
      mul_in1  <= '0;
      mul_in2  <= '0;
    end else begin
      if (accept) begin
        mul_in1 <= a_sel;
        mul_in2 <= b_sel;
        id_q    <= idx;
        ptr_q   <= ptr_next;
        if (bypass) result_q <= '0;
      end
      if ((state_q == ST_WAIT) && mul_done) result_q <= mul_out;
    end
  end

endmodule

// File: tb/tb_mul_arb.sv
// Directed self-checking bench for mul_arb with a 3-cycle behavioural multiplier.
module tb_mul_arb;

  localparam int N  = 4;
  localparam int DW = 16;
  localparam int RW = 32;
  localparam int L  = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          mul_start;
  logic [DW-1:0] mul_in1, mul_in2;
  logic [RW-1:0] mul_out;
  logic          mul_done;
  logic          model_done;
  logic          spur_done = 1'b0;
  logic          busy;
  int            cnt;

  int n_checks = 0;
  int n_fail   = 0;

  mul_arb_if #(.N_REQ(N), .DATA_W(DW)) bus ();

  mul_arb #(.N_REQ(N), .DATA_W(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .mul_start (mul_start),
    .mul_in1   (mul_in1),
    .mul_in2   (mul_in2),
    .mul_out   (mul_out),
    .mul_done  (mul_done)
  );

  always #5 clk = ~clk;

  assign mul_done = model_done | spur_done;

  // Multiplier model: done L cycles after the start cycle, product taken from the inputs then.
  always @(posedge clk) begin
    model_done <= 1'b0;
    if (reset) begin
      busy    <= 1'b0;
      cnt     <= 0;
      mul_out <= '0;
    end else if (mul_start) begin
      busy <= 1'b1;
      cnt  <= L - 1;
    end else if (busy) begin
      cnt <= cnt - 1;
      if (cnt == 1) begin
        busy       <= 1'b0;
        model_done <= 1'b1;
        mul_out    <= RW'(mul_in1) * RW'(mul_in2);
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_req_ready"}, 64'(bus.req_ready), 64'(0));
    check({tag, "_rsp_valid"}, 64'(bus.rsp_valid), 64'(0));
    check({tag, "_rsp_data"},  64'(bus.rsp_data),  64'(0));
    check({tag, "_rsp_id"},    64'(bus.rsp_id),    64'(0));
    check({tag, "_mul_start"}, 64'(mul_start),     64'(0));
    check({tag, "_mul_in1"},   64'(mul_in1),       64'(0));
    check({tag, "_mul_in2"},   64'(mul_in2),       64'(0));
  endtask

  // Called at a negedge in IDLE with rsp_ready[r] high; returns at the negedge after the response.
  task automatic run_txn(input int r, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic [RW-1:0] exp, input int exp_lat, input int exp_starts);
    int   lat, starts;
    logic held, seen_done;
    bus.req_a[r*DW +: DW] = a;
    bus.req_b[r*DW +: DW] = b;
    bus.req_valid[r]      = 1'b1;
    #1 check("grant", 64'(bus.req_ready), 64'(1 << r));
    @(negedge clk);
    bus.req_valid[r] = 1'b0;
    lat = 1; starts = 0; held = 1'b1; seen_done = 1'b0;
    while (bus.rsp_valid == '0 && lat < 40) begin
      if (mul_start) starts++;
      if (!seen_done && (mul_in1 != a || mul_in2 != b)) held = 1'b0;
      if (mul_done) seen_done = 1'b1;
      @(negedge clk);
      lat++;
    end
    check("latency",   64'(lat),           64'(exp_lat));
    check("starts",    64'(starts),        64'(exp_starts));
    if (exp_starts > 0) check("op_hold", 64'(held), 64'(1));
    check("rsp_valid", 64'(bus.rsp_valid), 64'(1 << r));
    check("rsp_data",  64'(bus.rsp_data),  64'(exp));
    check("rsp_id",    64'(bus.rsp_id),    64'(r));
    @(negedge clk);
    check("rsp_drop",  64'(bus.rsp_valid), 64'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   w;
    logic stable, no_ready, no_rsp;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = '1;
    reset         = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_vals("por");
    reset = 1'b0;
    @(negedge clk);

    // Single request: 8648 * 2301
    run_txn(0, 16'd8648, 16'd2301, 32'd19899048, L + 2, 1);

    // Round robin from ptr = 0 with all four requesters valid
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    bus.req_a     = {16'd65535, 16'd13, 16'd7, 16'd3};
    bus.req_b     = {16'd65535, 16'd17, 16'd11, 16'd5};
    bus.req_valid = '1;
    run_txn(0, 16'd3,     16'd5,     32'd15,         L + 2, 1);
    run_txn(1, 16'd7,     16'd11,    32'd77,         L + 2, 1);
    run_txn(2, 16'd13,    16'd17,    32'd221,        L + 2, 1);
    run_txn(3, 16'd65535, 16'd65535, 32'd4294836225, L + 2, 1);

    // Response backpressure on requester 1; other rsp_ready bits high but irrelevant
    bus.rsp_ready = 4'b1101;
    bus.req_a[1*DW +: DW] = 16'd100;
    bus.req_b[1*DW +: DW] = 16'd200;
    bus.req_valid[1] = 1'b1;
    #1 check("bp_grant", 64'(bus.req_ready), 64'(4'b0010));
    @(negedge clk);
    bus.req_valid[1] = 1'b0;
    w = 0;
    while (bus.rsp_valid == '0 && w < 40) begin
      @(negedge clk);
      w++;
    end
    bus.req_a[3*DW +: DW] = 16'd9;
    bus.req_b[3*DW +: DW] = 16'd9;
    bus.req_valid[3] = 1'b1;
    stable = 1'b1; no_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (bus.rsp_valid != 4'b0010 || bus.rsp_data != 32'd20000 || bus.rsp_id != 2'd1) stable = 1'b0;
      if (bus.req_ready != '0) no_ready = 1'b0;
      @(negedge clk);
    end
    check("bp_stable",   64'(stable),        64'(1));
    check("bp_no_ready", 64'(no_ready),      64'(1));
    check("bp_data",     64'(bus.rsp_data),  64'(20000));
    bus.rsp_ready[1] = 1'b1;
    #1 check("bp_ready_same_cycle", 64'(bus.req_ready), 64'(0));
    @(negedge clk);
    check("bp_next_grant", 64'(bus.req_ready), 64'(4'b1000));
    bus.rsp_ready = '1;
    run_txn(3, 16'd9, 16'd9, 32'd81, L + 2, 1);

    // Spurious done while idle: no response, pointer stays at 0
    spur_done = 1'b1;
    @(negedge clk);
    spur_done = 1'b0;
    check("spur_rsp_valid", 64'(bus.rsp_valid), 64'(0));
    check("spur_mul_start", 64'(mul_start),     64'(0));
    @(negedge clk);
    check("spur_rsp_later", 64'(bus.rsp_valid), 64'(0));
    bus.req_a[0*DW +: DW] = 16'd2;
    bus.req_b[0*DW +: DW] = 16'd21;
    bus.req_valid = 4'b1001;
    #1 check("spur_ptr", 64'(bus.req_ready), 64'(4'b0001));
    bus.req_valid[3] = 1'b0;
    run_txn(0, 16'd2, 16'd21, 32'd42, L + 2, 1);

    // Zero operand on requester 2
`ifdef MUL_ARB_ZERO_BYPASS_EN
    run_txn(2, 16'd0, 16'd1234, 32'd0, 1, 0);
`else
    run_txn(2, 16'd0, 16'd1234, 32'd0, L + 2, 1);
`endif

    // Reset while in WAIT: everything returns to reset values, no response follows
    bus.req_a[2*DW +: DW] = 16'd50;
    bus.req_b[2*DW +: DW] = 16'd60;
    bus.req_valid[2] = 1'b1;
    #1 check("rst_grant", 64'(bus.req_ready), 64'(4'b0100));
    @(negedge clk);
    bus.req_valid[2] = 1'b0;
    @(negedge clk);
    check("rst_pre_in1", 64'(mul_in1), 64'(50));
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_reset_vals("rst");
    no_rsp = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.rsp_valid != '0 || mul_start) no_rsp = 1'b0;
    end
    check("rst_no_rsp", 64'(no_rsp), 64'(1));
    bus.req_valid = 4'b1001;
    #1 check("rst_ptr", 64'(bus.req_ready), 64'(4'b0001));
    bus.req_valid = '0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
